// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg: shared types and sizes for the BCD conversion scheduler
package bcd_sched_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam int BIN_W = 8;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CONV_CYCLES = 8;
    localparam int CNT_W = $clog2(CONV_CYCLES);
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one shift-and-add-3 iteration on {bcd, operand}
module bcd_dabble_step
    import bcd_sched_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [BIN_W-1:0] bin_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic [BIN_W-1:0] bin_out
);
    logic [BCD_W-1:0] adj;
    always_comb begin
        adj = bcd_in;
        for (int d = 0; d < BCD_DIGITS; d++)
            adj[4*d +: 4] = (bcd_in[4*d +: 4] >= 4'd5) ? bcd_in[4*d +: 4] + 4'd3 : bcd_in[4*d +: 4];
    end
    assign {bcd_out, bin_out} = {adj, bin_in} << 1;
endmodule

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: round-robin sharing of one iterative binary-to-BCD converter
module bcd_convert_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [BIN_W*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [BCD_W-1:0]         rsp_bcd,
    output logic                     busy
);
    state_t state, state_nxt;
    logic [ID_W-1:0] ptr, win, idx;
    logic found, accept;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] bin, bin_nx;
    logic [BCD_W-1:0] bcd, bcd_nx;
    // Smaller offsets are visited last and overwrite, so the nearest requester after ptr wins
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req_valid[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end
    assign accept = (state == IDLE) && found;
    assign req_ready = accept ? NUM_REQ'(1) << win : '0;
    assign rsp_valid = state == DONE;
    assign busy = state != IDLE;
    assign rsp_bcd = bcd;
    bcd_dabble_step u_step (
        .bcd_in  (bcd),
        .bin_in  (bin),
        .bcd_out (bcd_nx),
        .bin_out (bin_nx)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = accept ? CONV :
                    (state == CONV && cnt == CNT_W'(CONV_CYCLES - 1)) ? DONE :
                    (state == DONE && rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(NUM_REQ - 1);
            rsp_id <= '0;
            cnt <= '0;
            bin <= '0;
            bcd <= '0;
        end else if (accept) begin
            ptr <= win;
            rsp_id <= win;
            cnt <= '0;
            bin <= BIN_W'(req_value >> (BIN_W * int'(win)));
            bcd <= '0;
        end else if (state == CONV) begin
            cnt <= cnt + 1'b1;
            bin <= bin_nx;
            bcd <= bcd_nx;
        end
    end
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb_bcd_convert_scheduler: randomized self-checking bench against a decimal-arithmetic model
module tb_bcd_convert_scheduler;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] req_valid, req_ready;
    logic [8*N-1:0] req_value;
    logic rsp_valid, rsp_ready, busy;
    logic [1:0] rsp_id;
    logic [11:0] rsp_bcd;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    bcd_convert_scheduler #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_value (req_value),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bcd   (rsp_bcd),
        .busy      (busy)
    );

    function automatic logic [11:0] ref_bcd(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int rr_pick(int p, logic [N-1:0] v);
        for (int o = 1; o <= N; o++) if (v[(p + o) % N]) return (p + o) % N;
        return -1;
    endfunction

    function automatic int onehot_idx(logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r == (N'(1) << i)) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_value = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic convert(input int id, input logic [7:0] v, output logic [11:0] bcd,
                           output logic [1:0] rid, output bit ok);
        req_value[8*id +: 8] = v;
        req_valid = N'(1) << id;
        ok = 1'b0;
        bcd = '0;
        rid = '0;
        for (int c = 0; c < 40; c++) begin
            if (busy) req_valid = '0;
            if (rsp_valid) begin
                bcd = rsp_bcd;
                rid = rsp_id;
                ok = 1'b1;
                break;
            end
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_value = '0;
        #2;
        vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        vectors++; if (rsp_id !== '0) begin miscompares++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        vectors++; if (rsp_bcd !== '0) begin miscompares++; $display("FAIL reset_rsp_bcd got %h want 000", rsp_bcd); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_value[8*2 +: 8] = 8'd255;
        req_valid = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_grant got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        repeat (7) step();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got %b want 0", rsp_valid); end
        step();
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency got %b want 1", rsp_valid); end
        vectors++; if (rsp_bcd !== 12'h255) begin miscompares++; $display("FAIL single_bcd got %h want 255", rsp_bcd); end
        vectors++; if (rsp_id !== 2'd2) begin miscompares++; $display("FAIL single_id got %0d want 2", rsp_id); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_release got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_values();
        int bval[7] = '{0, 9, 10, 99, 100, 199, 200};
        logic [11:0] bexp[7] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199, 12'h200};
        logic [11:0] got;
        logic [1:0] rid;
        bit ok;
        int id;
        for (int i = 0; i < 7; i++) begin
            id = int'($urandom_range(0, N - 1));
            convert(id, 8'(bval[i]), got, rid, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL boundary_timeout value %0d got no rsp want rsp", bval[i]); end
            vectors++; if (got !== bexp[i]) begin miscompares++; $display("FAIL boundary_bcd value %0d got %h want %h", bval[i], got, bexp[i]); end
            vectors++; if (rid !== 2'(id)) begin miscompares++; $display("FAIL boundary_id got %0d want %0d", rid, id); end
        end
        for (int v = 0; v < 256; v++) begin
            id = int'($urandom_range(0, N - 1));
            convert(id, 8'(v), got, rid, ok);
            vectors++; if (!ok || got !== ref_bcd(v) || rid !== 2'(id))
                begin miscompares++; $display("FAIL sweep value %0d got ok=%b bcd=%h id=%0d want bcd=%h id=%0d", v, ok, got, rid, ref_bcd(v), id); end
        end
    endtask

    task automatic test_back_to_back();
        int vals[4] = '{7, 42, 128, 199};
        int eid[5] = '{0, 1, 2, 3, 0};
        logic [11:0] ebcd[5] = '{12'h007, 12'h042, 12'h128, 12'h199, 12'h007};
        int got = 0, last = 0;
        hard_reset();
        for (int i = 0; i < N; i++) req_value[8*i +: 8] = 8'(vals[i]);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
            if (rsp_valid) begin
                vectors++; if (rsp_id !== 2'(eid[got])) begin miscompares++; $display("FAIL rr_order #%0d got %0d want %0d", got, rsp_id, eid[got]); end
                vectors++; if (rsp_bcd !== ebcd[got]) begin miscompares++; $display("FAIL rr_bcd #%0d got %h want %h", got, rsp_bcd, ebcd[got]); end
                if (got > 0) begin
                    vectors++; if (cyc - last != 10) begin miscompares++; $display("FAIL rr_spacing #%0d got %0d want 10", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
            step();
        end
        vectors++; if (got != 5) begin miscompares++; $display("FAIL rr_timeout got %0d rsps want 5", got); end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int v = int'($urandom_range(0, 255));
        logic [11:0] exp = ref_bcd(v);
        hard_reset();
        req_value[8*1 +: 8] = 8'(v);
        req_valid = 4'b0010;
        for (int c = 0; c < 30 && !rsp_valid; c++) begin
            if (busy) req_valid = 4'b1000;
            step();
        end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_timeout got %b want 1", rsp_valid); end
        for (int c = 0; c < 20; c++) begin
            vectors++; if (rsp_valid !== 1'b1 || rsp_bcd !== exp || rsp_id !== 2'd1 || req_ready !== '0)
                begin miscompares++; $display("FAIL bp_hold cycle %0d got v=%b bcd=%h id=%0d rdy=%b want 1 %h 1 0000", c, rsp_valid, rsp_bcd, rsp_id, req_ready, exp); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got %b want 0", rsp_valid); end
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_idle_grant got %b want 1000", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_midconv();
        int rv = int'($urandom_range(0, 255));
        hard_reset();
        req_value[8*2 +: 8] = 8'd150;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (3) step();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_bcd !== '0 || busy !== 1'b0)
            begin miscompares++; $display("FAIL mid_async_reset got rdy=%b v=%b id=%0d bcd=%h busy=%b want all 0", req_ready, rsp_valid, rsp_id, rsp_bcd, busy); end
        req_value[7:0] = 8'(rv);
        req_valid = 4'b0101;
        step();
        rst_n = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        for (int c = 0; c < 7; c++) begin
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale_valid cycle %0d got 1 want 0", c); end
            step();
        end
        step();
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_bcd !== ref_bcd(rv))
            begin miscompares++; $display("FAIL mid_after_reset got v=%b id=%0d bcd=%h want 1 0 %h", rsp_valid, rsp_id, rsp_bcd, ref_bcd(rv)); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_no_starvation();
        int egrant[3] = '{1, 3, 1};
        int mptr = N - 1, ng = 0, g, e;
        bit sent3 = 1'b0, got3 = 1'b0;
        hard_reset();
        req_value[8*1 +: 8] = 8'($urandom_range(0, 255));
        req_value[8*3 +: 8] = 8'($urandom_range(0, 255));
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            if (req_ready !== '0) begin
                g = onehot_idx(req_ready);
                e = rr_pick(mptr, req_valid);
                vectors++; if (g != e || g != egrant[ng]) begin miscompares++; $display("FAIL rotate #%0d got %0d want %0d", ng, g, egrant[ng]); end
                mptr = e;
                if (g == 3) got3 = 1'b1;
                ng++;
            end
            if (busy && ng == 1 && !sent3) begin req_valid[3] = 1'b1; sent3 = 1'b1; end
            if (busy && got3) req_valid[3] = 1'b0;
            step();
        end
        vectors++; if (ng != 3) begin miscompares++; $display("FAIL rotate_timeout got %0d grants want 3", ng); end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_values();
        test_back_to_back();
        test_backpressure();
        test_reset_midconv();
        test_no_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_convert_scheduler.md
Name: bcd_convert_scheduler

Overview:
- Shares one iterative 8-bit binary-to-BCD converter (shift-and-add-3) between NUM_REQ requesters, e.g. score, lives, level and timer feeding the Nexys7 seven-segment display path.
- Round-robin arbitration, valid/ready request handshake, tagged valid/ready response.
- Sits between game-state registers and the display digit registers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_value  in  8*NUM_REQ  per-requester binary operand; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot grant/accept.
- rsp_valid  out  1  conversion result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester whose result is presented.
- rsp_bcd  out  12  result {hundreds, tens, ones} nibbles; the hundreds nibble is 0..2.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_bcd=0, busy=0, RR pointer=NUM_REQ-1 so requester 0 wins first, shift/BCD registers=0.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - The winner is the first asserted req_valid searching from pointer+1, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle. Handshake completes in that cycle.
  - On that edge: latch req_value[winner] into the operand shift register, clear the BCD accumulator, latch the winner into rsp_id, set pointer=winner, set bit counter=0, go to CONV.
  - With no req_valid asserted, remain in IDLE and keep req_ready=0.
- CONV:
  - One iteration per cycle. First add 3 to each BCD nibble that is >=5. Then shift {bcd, operand} left by 1, bringing the operand MSB into bcd[0].
  - Exactly 8 cycles. After the 8th, go to DONE.
  - req_ready=0 throughout. req_valid is ignored; requesters hold their request.
- DONE:
  - rsp_valid=1; rsp_bcd and rsp_id are stable.
  - On rsp_valid&rsp_ready: go to IDLE and deassert rsp_valid on the next cycle.
  - Back-pressure: stay in DONE indefinitely and hold all outputs.
- Latency: request accepted at edge k; rsp_valid high from cycle k+9. Back-to-back throughput is 10 cycles per conversion when rsp_ready is held high (the IDLE cycle is mandatory).
- Arithmetic: 8-bit input gives 3 BCD digits with max value 0x255. Nibbles never exceed 9 after correction. No overflow is possible; hundreds bits [11:10] are always 0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- req_valid dropped before its grant means no request. The block does not flag it.
- Reset mid-CONV or mid-DONE: immediate return to the reset values. The in-flight result is discarded, and no rsp_valid pulse follows reset release.
- rsp_ready while rsp_valid=0 has no effect.

Decomposition:
- Package bcd_sched_pkg:
  - state_t enum {IDLE, CONV, DONE}.
  - BIN_W=8, BCD_DIGITS=3, BCD_W=12, CONV_CYCLES=8.
- Sub-module bcd_dabble_step: combinational single iteration (add-3 correction plus shift) on {bcd[11:0], operand[7:0]}.
  - Instantiated once inside the CONV register path.
  - Unit-testable exhaustively by stepping.

Test Plan:
- Single request, id 2, value 8'd255 → req_ready[2] in the same cycle; rsp_valid exactly 9 cycles after acceptance; rsp_bcd=12'h255, rsp_id=2.
- Boundary values: 0, 9, 10, 99, 100, 199, 200 → 12'h000, 009, 010, 099, 100, 199, 200 respectively. Also sweep all 256 inputs against a reference model.
- All four requesters valid with values 7, 42, 128, 199, rsp_ready held high → responses in id order 0, 1, 2, 3 (12'h007, 042, 128, 199), then 0 again; 10-cycle spacing.
- Back-pressure: rsp_ready=0 for 20 cycles in DONE → rsp_valid, rsp_bcd and rsp_id held; req_ready stays 0; release with one cycle of rsp_ready=1 → IDLE next cycle.
- Reset asserted at the 4th CONV cycle of a 8'd150 conversion → all outputs 0 asynchronously. After release, the next grant goes to requester 0 and no stale rsp_valid appears.
- Requester 1 continuously valid while requester 3 asserts once → grants go 1, 3, 1 (rotation is honoured and no starvation).
